// File: rtl/pipelined_adder.sv
// Pipelined adder/subtractor: each stage sums one WIDTH/STAGES-bit chunk and hands its
// carry plus the not-yet-summed operand bits to the next stage, with tag and valid alongside.
module pipelined_adder #(
    parameter int WIDTH     = 32,
    parameter int STAGES    = 4,
    parameter int TAG_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_sub,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_sum,
    output logic                 out_co,
    output logic                 out_ovf,
    output logic [TAG_WIDTH-1:0] out_tag
);

    localparam int C = WIDTH / STAGES;

    logic [STAGES-1:0] r_vld;
    logic [STAGES-1:0] w_vsrc;
    logic [STAGES-1:0] w_rdy;

    function automatic logic [C:0] chunk_add(input logic [C-1:0] a, input logic [C-1:0] b,
                                             input logic cin);
        return {1'b0, a} + {1'b0, b} + {{C{1'b0}}, cin};
    endfunction

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_vld <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (w_rdy[i]) r_vld[i] <= w_vsrc[i];
            end
        end
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic [WIDTH-1:0]     w_a_src;
        logic [WIDTH-1:0]     w_b_src;
        logic [WIDTH-1:0]     w_sum_src;
        logic [WIDTH-1:0]     w_sum_nxt;
        logic                 w_c_src;
        logic [TAG_WIDTH-1:0] w_tag_src;
        logic [C:0]           w_chunk;
        logic                 w_load;
        logic [WIDTH-1:0]     r_sum;
        logic                 r_c;
        logic [TAG_WIDTH-1:0] r_tag;

        // A stage may advance when it or any stage after it is empty, or the consumer takes.
        assign w_rdy[i] = out_ready || !(&r_vld[STAGES-1:i]);

        if (i == 0) begin : g_src
            assign w_a_src   = in_a;
            assign w_b_src   = in_sub ? ~in_b : in_b;
            assign w_c_src   = in_sub;
            assign w_sum_src = '0;
            assign w_tag_src = in_tag;
            assign w_vsrc[i] = in_valid;
        end else begin : g_src
            assign w_a_src   = g_stage[i-1].g_fwd.r_a;
            assign w_b_src   = g_stage[i-1].g_fwd.r_b;
            assign w_c_src   = g_stage[i-1].r_c;
            assign w_sum_src = g_stage[i-1].r_sum;
            assign w_tag_src = g_stage[i-1].r_tag;
            assign w_vsrc[i] = r_vld[i-1];
        end

        assign w_chunk = chunk_add(w_a_src[C*i +: C], w_b_src[C*i +: C], w_c_src);
        assign w_load  = w_rdy[i] && w_vsrc[i];

        always_comb begin
            w_sum_nxt            = w_sum_src;
            w_sum_nxt[C*i +: C]  = w_chunk[C-1:0];
        end

        if (i == STAGES-1) begin : g_out
            logic r_ovf;
            logic w_unused;
            assign w_unused = ^{w_a_src, w_b_src};

            // Output stage: data is reset so out_* read 0 until the first result.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sum <= '0;
                    r_c   <= 1'b0;
                    r_tag <= '0;
                    r_ovf <= 1'b0;
                end else if (w_load) begin
                    r_sum <= w_sum_nxt;
                    r_c   <= w_chunk[C];
                    r_tag <= w_tag_src;
                    r_ovf <= (w_a_src[WIDTH-1] == w_b_src[WIDTH-1]) &&
                             (w_sum_nxt[WIDTH-1] != w_a_src[WIDTH-1]);
                end
            end
        end else begin : g_fwd
            logic [WIDTH-1:0] r_a;
            logic [WIDTH-1:0] r_b;

            always_ff @(posedge clk) begin
                if (w_load) begin
                    r_a   <= w_a_src;
                    r_b   <= w_b_src;
                    r_sum <= w_sum_nxt;
                    r_c   <= w_chunk[C];
                    r_tag <= w_tag_src;
                end
            end
        end
    end

    assign in_ready  = w_rdy[0];
    assign out_valid = r_vld[STAGES-1];
    assign out_sum   = g_stage[STAGES-1].r_sum;
    assign out_co    = g_stage[STAGES-1].r_c;
    assign out_tag   = g_stage[STAGES-1].r_tag;
    assign out_ovf   = g_stage[STAGES-1].g_out.r_ovf;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed corner cases, stall/bubble/flush/reset
// scenarios, and a randomized run against an arithmetic reference model and result queue.
module tb_pipelined_adder;
    localparam int W = 32;
    localparam int S = 4;
    localparam int T = 6;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         co;
        logic         ovf;
        logic [T-1:0] tag;
    } res_t;

    logic         clk = 1'b0;
    logic         rst, flush, in_valid, in_ready, in_sub, out_valid, out_ready, out_co, out_ovf;
    logic [W-1:0] in_a, in_b, out_sum;
    logic [T-1:0] in_tag, out_tag;
    int           nvec = 0;
    int           nerr = 0;
    res_t         q[$];

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(W), .STAGES(S), .TAG_WIDTH(T)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_sub(in_sub), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_co(out_co), .out_ovf(out_ovf), .out_tag(out_tag)
    );

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sub, input logic [T-1:0] tag);
        res_t r;
        logic [W:0] wide;
        r.tag = tag;
        if (!sub) begin
            wide  = {1'b0, a} + {1'b0, b};
            r.sum = wide[W-1:0];
            r.co  = wide[W];
            r.ovf = (a[W-1] == b[W-1]) && (r.sum[W-1] != a[W-1]);
        end else begin
            r.sum = a - b;
            r.co  = (a >= b);
            r.ovf = (a[W-1] != b[W-1]) && (r.sum[W-1] != a[W-1]);
        end
        return r;
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input logic [T-1:0] tag);
        in_valid = v; in_a = a; in_b = b; in_sub = sub; in_tag = tag;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, '0, '0, 1'b0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        nvec++; if (out_sum !== '0) begin nerr++; $display("FAIL reset_sum: got %h want 0", out_sum); end
        nvec++; if (out_tag !== '0) begin nerr++; $display("FAIL reset_tag: got %h want 0", out_tag); end
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_single_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                                  input logic [T-1:0] tag, input res_t exp, input string name);
        out_ready = 1'b1;
        @(negedge clk);
        drive(1'b1, a, b, sub, tag);
        #1;
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL %s_accept: got %b want 1", name, in_ready); end
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b0, '0);
        for (int c = 1; c < S; c++) begin
            nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL %s_early: cycle %0d got valid %b want 0", name, c, out_valid); end
            @(negedge clk);
        end
        nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL %s_latency: got valid %b want 1", name, out_valid); end
        nvec++; if ({out_sum, out_co, out_ovf, out_tag} !== exp) begin
            nerr++; $display("FAIL %s_result: got %h want %h", name, {out_sum, out_co, out_ovf, out_tag}, exp);
        end
        @(negedge clk);
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL %s_drain: got valid %b want 0", name, out_valid); end
    endtask

    task automatic test_carry_chain();
        test_single_op(32'hFFFFFFFF, 32'h1, 1'b0, 6'd5, {32'h00000000, 1'b1, 1'b0, 6'd5}, "carry_wrap");
        test_single_op(32'h7FFFFFFF, 32'h1, 1'b0, 6'd6, {32'h80000000, 1'b0, 1'b1, 6'd6}, "carry_ovf");
    endtask

    task automatic test_subtract();
        test_single_op(32'h5, 32'h7, 1'b1, 6'd7, {32'hFFFFFFFE, 1'b0, 1'b0, 6'd7}, "sub_borrow");
        test_single_op(32'h80000000, 32'h1, 1'b1, 6'd8, {32'h7FFFFFFF, 1'b1, 1'b1, 6'd8}, "sub_ovf");
    endtask

    task automatic test_stream_stall();
        int n = 0;
        int got = 0;
        int seen = 0;
        res_t exp;
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            drive(1'b1, W'(n), W'(n), 1'b0, T'(n));
            #1;
            nvec++; if (in_ready !== (c < S)) begin nerr++; $display("FAIL stall_ready: cycle %0d got %b want %b", c, in_ready, (c < S)); end
            if (c >= S) begin
                nvec++; if ({out_valid, out_tag} !== {1'b1, 6'd0}) begin
                    nerr++; $display("FAIL stall_hold: cycle %0d got valid %b tag %0d want valid 1 tag 0", c, out_valid, out_tag);
                end
            end
            if (in_ready) n++;
        end
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (n < 8) drive(1'b1, W'(n), W'(n), 1'b0, T'(n));
            else       drive(1'b0, '0, '0, 1'b0, '0);
            #1;
            if (out_valid) begin
                exp = model(W'(got), W'(got), 1'b0, T'(got));
                nvec++; if ({out_sum, out_co, out_ovf, out_tag} !== exp) begin
                    nerr++; $display("FAIL stream_order: got %h want %h", {out_sum, out_co, out_ovf, out_tag}, exp);
                end
                got++;
            end
            if (in_valid && in_ready) n++;
        end
        nvec++; if (got !== 8) begin nerr++; $display("FAIL stream_count: got %0d results want 8", got); end
        drive(1'b0, '0, '0, 1'b0, '0);
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        nvec++; if (seen !== 0) begin nerr++; $display("FAIL stream_dup: got %0d extra results want 0", seen); end
    endtask

    task automatic test_bubble_collapse();
        logic vpat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        int   tpat [7] = '{1, 0, 0, 2, 3, 4, 5};
        logic [W-1:0] a, b;
        logic sub;
        q.delete();
        out_ready = 1'b0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
            drive(vpat[c], a, b, sub, T'(tpat[c]));
            #1;
            nvec++; if (in_ready !== (q.size() < S)) begin
                nerr++; $display("FAIL bubble_ready: cycle %0d got %b want %b", c, in_ready, (q.size() < S));
            end
            if (in_valid && in_ready) q.push_back(model(a, b, sub, T'(tpat[c])));
        end
        for (int cyc = 0; cyc < 20 && q.size() > 0; cyc++) begin
            @(negedge clk);
            out_ready = 1'b1;
            drive(1'b0, '0, '0, 1'b0, '0);
            #1;
            if (out_valid) begin
                nvec++; if ({out_sum, out_co, out_ovf, out_tag} !== q[0]) begin
                    nerr++; $display("FAIL bubble_result: got %h want %h", {out_sum, out_co, out_ovf, out_tag}, q[0]);
                end
                void'(q.pop_front());
            end
        end
        nvec++; if (q.size() !== 0) begin nerr++; $display("FAIL bubble_timeout: got %0d pending want 0", q.size()); end
        @(negedge clk);
    endtask

    task automatic test_flush();
        int seen = 0;
        logic [W-1:0] a, b;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(1'b1, $urandom, $urandom, 1'b0, T'(10 + c));
        end
        @(negedge clk);
        drive(1'b1, $urandom, $urandom, 1'b1, 6'd13);
        flush = 1'b1;
        #1;
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL flush_ready: got %b want 1", in_ready); end
        if (out_valid) seen++;
        @(negedge clk);
        flush = 1'b0;
        drive(1'b0, '0, '0, 1'b0, '0);
        repeat (10) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        nvec++; if (seen !== 0) begin nerr++; $display("FAIL flush_leak: got %0d results want 0", seen); end
        a = $urandom; b = $urandom;
        test_single_op(a, b, 1'b1, 6'd21, model(a, b, 1'b1, 6'd21), "post_flush");
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        logic sub, v;
        logic held = 1'b0;
        res_t prev = '0;
        res_t cur;
        q.delete();
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
            v = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            drive(v, a, b, sub, T'($urandom_range(0, 63)));
            #1;
            cur = {out_sum, out_co, out_ovf, out_tag};
            nvec++; if (in_ready !== (out_ready || q.size() < S)) begin
                nerr++; $display("FAIL rand_ready: cycle %0d got %b want %b", cyc, in_ready, (out_ready || q.size() < S));
            end
            if (held) begin
                nvec++; if ({out_valid, cur} !== {1'b1, prev}) begin
                    nerr++; $display("FAIL rand_hold: cycle %0d got %b/%h want 1/%h", cyc, out_valid, cur, prev);
                end
            end
            if (out_valid) begin
                nvec++;
                if (q.size() == 0) begin
                    nerr++; $display("FAIL rand_spurious: cycle %0d got %h want no result", cyc, cur);
                end else if (out_ready) begin
                    if (cur !== q[0]) begin
                        nerr++; $display("FAIL rand_result: cycle %0d got %h want %h", cyc, cur, q[0]);
                    end
                    void'(q.pop_front());
                end
            end
            held = out_valid && !out_ready;
            prev = cur;
            if (in_valid && in_ready) q.push_back(model(a, b, sub, in_tag));
        end
        for (int cyc = 0; cyc < 20 && q.size() > 0; cyc++) begin
            @(negedge clk);
            out_ready = 1'b1;
            drive(1'b0, '0, '0, 1'b0, '0);
            #1;
            if (out_valid) begin
                nvec++; if ({out_sum, out_co, out_ovf, out_tag} !== q[0]) begin
                    nerr++; $display("FAIL rand_drain: got %h want %h", {out_sum, out_co, out_ovf, out_tag}, q[0]);
                end
                void'(q.pop_front());
            end
        end
        nvec++; if (q.size() !== 0) begin nerr++; $display("FAIL rand_timeout: got %0d pending want 0", q.size()); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        out_ready = 1'b0;
        @(negedge clk); drive(1'b1, 32'h1234, 32'h1, 1'b0, 6'd30);
        @(negedge clk); drive(1'b1, 32'h5678, 32'h2, 1'b0, 6'd31);
        @(negedge clk); drive(1'b1, 32'h9ABC, 32'h3, 1'b0, 6'd32);
        rst = 1'b1; flush = 1'b1;
        @(negedge clk);
        rst = 1'b0; flush = 1'b0;
        drive(1'b0, '0, '0, 1'b0, '0);
        out_ready = 1'b1;
        #1;
        nvec++; if ({out_valid, out_sum, out_co, out_ovf, out_tag} !== '0) begin
            nerr++; $display("FAIL midrst_clear: got %h want 0", {out_valid, out_sum, out_co, out_ovf, out_tag});
        end
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL midrst_ready: got %b want 1", in_ready); end
        repeat (8) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        nvec++; if (seen !== 0) begin nerr++; $display("FAIL midrst_leak: got %0d results want 0", seen); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_carry_chain();
        test_subtract();
        test_stream_stall();
        test_bubble_collapse();
        test_flush();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
